// File: rtl/inst_fetch.sv
// Instruction fetch: PC, imem req/ack handshake, holding register for decode.
// Optional halt-on-FFFFFFFF behaviour is enabled by defining IFETCH_HALT_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [5:0]  inst_1,
    output logic [5:0]  inst_2,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err,
    output logic        halted
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
`ifdef IFETCH_HALT_EN
        HALT,
`endif
        ERR
    } state_t;

    state_t        state, state_d;
    logic [31:0]   pc, pc_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   ipc_q, ipc_d;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        cnt_d   = cnt;
        word_d  = word_q;
        ipc_d   = ipc_q;
        unique case (state)
            IDLE, REQ, HOLD: begin
                // Redirect outranks ack and ready in the same cycle
                if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d = ERR;
                    end else begin
                        pc_d    = redirect_pc;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end else if (state == IDLE) begin
                    cnt_d   = '0;
                    state_d = REQ;
                end else if (state == REQ) begin
                    if (imem_ack) begin
                        word_d  = imem_rdata;
                        ipc_d   = pc;
                        pc_d    = pc + 32'd4;
                        state_d = HOLD;
                    end else if (cnt == TMO) begin
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end else if (inst_ready) begin
`ifdef IFETCH_HALT_EN
                    if (word_q == 32'hFFFF_FFFF) begin
                        state_d = HALT;
                    end else begin
                        cnt_d   = '0;
                        state_d = REQ;
                    end
`else
                    cnt_d   = '0;
                    state_d = REQ;
`endif
                end
            end
            default: state_d = state;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            cnt    <= '0;
            word_q <= '0;
            ipc_q  <= '0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            cnt    <= cnt_d;
            word_q <= word_d;
            ipc_q  <= ipc_d;
        end
    end

    assign imem_req   = (state == REQ);
    assign imem_addr  = pc;
    assign inst_valid = (state == HOLD);
    assign inst_word  = word_q;
    assign inst_1     = word_q[31:26];
    assign inst_2     = word_q[5:0];
    assign inst_pc    = ipc_q;
    assign fetch_err  = (state == ERR);
`ifdef IFETCH_HALT_EN
    assign halted     = (state == HALT);
`else
    assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an expected-instruction scoreboard.
// Covers both IFETCH_HALT_EN builds.
module tb_inst_fetch;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [5:0]  inst_1;
    logic [5:0]  inst_2;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_pc;
    logic [63:0] sb[$];

    inst_fetch #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(15)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word), .inst_1(inst_1), .inst_2(inst_2),
        .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_word"}, inst_word, 32'h0);
        chk({tag, "_ipc"}, inst_pc, 32'h0);
        chk({tag, "_err"}, 32'(fetch_err), 32'd0);
        chk({tag, "_halt"}, 32'(halted), 32'd0);
    endtask

    // Memory side: ack the pending request with word in one cycle
    task automatic serve(input string tag, input logic [31:0] w);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, exp_pc);
        sb.push_back({exp_pc, w});
        imem_ack = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack = 1'b0;
        exp_pc = exp_pc + 32'd4;
    endtask

    // Decode side: accept the held instruction and score it
    task automatic take(input string tag);
        int n = 0;
        logic [63:0] e;
        logic [31:0] ew;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            ew = e[31:0];
            chk({tag, "_pc"}, inst_pc, e[63:32]);
            chk({tag, "_word"}, inst_word, ew);
            chk({tag, "_op"}, 32'(inst_1), 32'(ew[31:26]));
            chk({tag, "_fn"}, 32'(inst_2), 32'(ew[5:0]));
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        tick();
        reset_checks("rst");
        reset_n = 1'b1;
        exp_pc = 32'h0;
        sb.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        exp_pc = 32'h0;
        #2;
        reset_checks("por");
        tick();
        do_reset();

        // One IDLE cycle, then request at RESET_PC
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        serve("f0", 32'h8C01_0000);
        take("f0");
        serve("f1", 32'hAC01_0004);
        take("f1");
        serve("f2", 32'h2001_0005);
        take("f2");
        chk("f2_op_lit", 32'(dut.inst_1), 32'(6'b001000));

        // R-type held while decode stalls
        serve("rt", 32'h0022_1820);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_op", 32'(inst_1), 32'd0);
            chk("stall_fn", 32'(inst_2), 32'(6'b100000));
            tick();
        end
        take("rt");

        // Redirect collides with ack: returned data dropped
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        exp_pc = 32'h40;
        chk("rd_req", 32'(imem_req), 32'd1);
        chk("rd_addr", imem_addr, 32'h40);
        chk("rd_valid", 32'(inst_valid), 32'd0);
        serve("rd", 32'h1234_5678);
        take("rd");

        // Redirect beats ready: held instruction dropped
        serve("rh", 32'h0000_0001);
        void'(sb.pop_back());
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        exp_pc = 32'h80;
        chk("rh_valid", 32'(inst_valid), 32'd0);
        chk("rh_addr", imem_addr, 32'h80);
        chk("rh_req", 32'(imem_req), 32'd1);

        // PC wraps modulo 2^32
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        serve("wr", 32'h1111_1111);
        take("wr");
        chk("wr_addr", imem_addr, 32'h0);
        chk("wr_err", 32'(fetch_err), 32'd0);
        serve("wr0", 32'h2222_2222);
        take("wr0");

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        chk("mis_err", 32'(fetch_err), 32'd1);
        chk("mis_req", 32'(imem_req), 32'd0);
        chk("mis_valid", 32'(inst_valid), 32'd0);

        // Timeout after TIMEOUT_CYCLES+1 cycles in REQ
        do_reset();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_pre_err", 32'(fetch_err), 32'd0);
        chk("to_pre_req", 32'(imem_req), 32'd1);
        tick();
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        imem_ack = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        chk("to_sticky", 32'(fetch_err), 32'd1);
        chk("to_sticky_req", 32'(imem_req), 32'd0);
        chk("to_sticky_valid", 32'(inst_valid), 32'd0);

        // Reset clears the error and restarts at RESET_PC
        do_reset();
        tick();
        serve("hl", 32'hFFFF_FFFF);
        take("hl");
`ifdef IFETCH_HALT_EN
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_valid", 32'(inst_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("halt_stay", 32'(halted), 32'd1);
        chk("halt_stay_req", 32'(imem_req), 32'd0);
`else
        chk("nohalt_flag", 32'(halted), 32'd0);
        chk("nohalt_req", 32'(imem_req), 32'd1);
        chk("nohalt_addr", imem_addr, 32'h4);
        serve("nh", 32'h0000_0020);
        take("nh");
`endif

        // Async reset mid-fetch with an ack pending
        do_reset();
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        #2;
        reset_n = 1'b0;
        #1;
        reset_checks("async");
        tick();
        reset_checks("async_hold");
        imem_ack = 1'b0;
        reset_n = 1'b1;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
